dff_clk_switch_n: RTL and testbench
===================================

DFF_CLK_SWITCH_N -- requirements
Module: dff_clk_switch_n

Interface
REQ-001 Parameter N_CH, default 4, number of divided-clock channels (2..8).
REQ-002 Parameter SEL_W, default 2, select width, SHALL satisfy 2^SEL_W >= N_CH.
REQ-003 Parameter RST_SEL, default 0, channel active after reset.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 select  input  SEL_W  requested channel index; sampled every cycle.
REQ-007 clk_out  output  1  registered, glitch-free divided clock of the active channel.
REQ-008 cur_sel  output  SEL_W  index of the channel currently driving clk_out.
REQ-009 busy  output  1  high while a switch is in progress (DRAIN or PARK).
REQ-010 sw_done  output  1  one-cycle pulse when a switch completes.
REQ-011 sel_err  output  1  one-cycle pulse when select >= N_CH is seen in RUN.

Function
REQ-012 Free-running counter cnt, N_CH bits, SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-013 Channel i phase SHALL be cnt[i]: period 2^(i+1) cycles, 50% duty; channel 0 = clk/2.
REQ-014 FSM states SHALL be RUN, DRAIN, PARK; encoding free.
REQ-015 RUN: clk_out <= cnt[cur_sel] each cycle (1-cycle latency from phase to pin).
REQ-016 RUN, select < N_CH and select != cur_sel: latch tgt <= select, go DRAIN, busy = 1 from the next cycle.
REQ-017 RUN, select >= N_CH: no state change, sel_err pulses for 1 cycle, repeated every cycle while invalid.
REQ-018 DRAIN: clk_out continues <= cnt[cur_sel]; when cnt[cur_sel] == 0, go PARK and drive clk_out <= 0.
REQ-019 PARK: clk_out held 0; after at least one full PARK cycle, when cnt[tgt] == 0, set cur_sel <= tgt, go RUN, pulse sw_done.
REQ-020 Any high pulse on clk_out SHALL last exactly the full high half-period of its channel; no truncated high pulse at any switch.
REQ-021 Low time on clk_out around a switch SHALL be >= 2 cycles and <= 2^N_CH + 2^N_CH + 2 cycles.
REQ-022 select changes during DRAIN/PARK SHALL be ignored; tgt stays latched.
REQ-023 On return to RUN, if select still differs from cur_sel, a new switch SHALL start that cycle.
REQ-024 select == cur_sel in RUN: no action, busy stays 0.
REQ-025 busy SHALL deassert in the same cycle that sw_done asserts.

Reset
REQ-026 rst_n low at a rising edge: cnt = 0, state = RUN, cur_sel = RST_SEL, tgt = RST_SEL, clk_out = 0, busy = 0, sw_done = 0, sel_err = 0.
REQ-027 Reset asserted mid-DRAIN or mid-PARK SHALL abort the switch with no sw_done pulse and apply REQ-026 values.
REQ-028 Outputs SHALL hold reset values for every cycle rst_n is low; first counting edge is the first edge with rst_n high.

Verification (N_CH=4, SEL_W=2, RST_SEL=0)
REQ-029 Release reset, select=0 -> clk_out toggles every cycle, period 2, busy=0, cur_sel=0.
REQ-030 In RUN on ch0, select=3 -> busy=1; clk_out low >= 2 cycles; then highs of exactly 8 cycles and period 16; sw_done pulses once; cur_sel=3.
REQ-031 During PARK toward ch2, change select 2->1 -> switch completes to ch2 (cur_sel=2), then second switch to ch1 starts immediately; two sw_done pulses total.
REQ-032 select=3 while ch3 high for 3 cycles -> remaining high completes to 8 cycles before clk_out low; no runt pulse anywhere (checker: every high run length == 2^cur_sel).
REQ-033 With N_CH=3, select=3 in RUN -> sel_err pulses each cycle, cur_sel unchanged, busy=0.
REQ-034 rst_n low for 1 cycle during DRAIN -> next cycle cur_sel=0, clk_out=0, busy=0, no sw_done.

Source files
------------

// File: rtl/dff_clk_switch_n.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dff_clk_switch_n                                              |
// | Brief    : Glitch-free selector over N_CH power-of-two divided clocks.   |
// |            A free-running counter supplies channel phases; a switch      |
// |            drains the current channel low, parks, then restarts on the   |
// |            target channel only at a phase boundary.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dff_clk_switch_n #(
  parameter int N_CH    = 4,
  parameter int SEL_W   = 2,
  parameter int RST_SEL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] select,
  output logic             clk_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             sw_done,
  output logic             sel_err
);

  localparam logic [1:0]       c_st_run   = 2'd0;
  localparam logic [1:0]       c_st_drain = 2'd1;
  localparam logic [1:0]       c_st_park  = 2'd2;
  localparam logic [SEL_W:0]   c_n_ch     = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] c_rst_sel  = SEL_W'(RST_SEL);
  localparam logic [N_CH-1:0]  c_cnt_one  = N_CH'(1);

  logic [N_CH-1:0]  r_cnt;
  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_cur_sel;
  logic [SEL_W-1:0] r_tgt;
  logic             r_park_hold;
  logic             r_clk_out;
  logic             r_sw_done;
  logic             r_sel_err;

  logic             w_cur_ph;
  logic             w_tgt_ph;
  logic             w_sel_valid;
  logic             w_sel_new;

  // Free-running divider counter; bit i is the phase of channel i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Pick the phase bits of the active and target channels without
  // indexing past the counter width.
  always_comb begin
    w_cur_ph = 1'b0;
    w_tgt_ph = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_cur_sel == SEL_W'(i)) w_cur_ph = r_cnt[i];
      if (r_tgt == SEL_W'(i))     w_tgt_ph = r_cnt[i];
    end
  end

  assign w_sel_valid = ({1'b0, select} < c_n_ch);
  assign w_sel_new   = w_sel_valid && (select != r_cur_sel);

  // Switch sequencer: follow the active phase in RUN, let the current high
  // half finish in DRAIN, hold low in PARK until the target phase is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_st_run;
      r_cur_sel   <= c_rst_sel;
      r_tgt       <= c_rst_sel;
      r_park_hold <= 1'b0;
      r_clk_out   <= 1'b0;
      r_sw_done   <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sw_done <= 1'b0;
      r_sel_err <= 1'b0;
      case (r_state)
        c_st_run: begin
          r_clk_out <= w_cur_ph;
          if (!w_sel_valid) begin
            r_sel_err <= 1'b1;
          end else if (w_sel_new) begin
            r_tgt   <= select;
            r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          // Leaving only on a low phase keeps every high pulse full length.
          r_clk_out <= w_cur_ph;
          if (!w_cur_ph) begin
            r_state     <= c_st_park;
            r_park_hold <= 1'b1;
          end
        end
        c_st_park: begin
          r_clk_out <= 1'b0;
          // The first PARK cycle is always spent low to guarantee a gap.
          if (r_park_hold) begin
            r_park_hold <= 1'b0;
          end else if (!w_tgt_ph) begin
            r_cur_sel <= r_tgt;
            r_state   <= c_st_run;
            r_sw_done <= 1'b1;
          end
        end
        default: begin
          r_state   <= c_st_run;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out = r_clk_out;
  assign cur_sel = r_cur_sel;
  assign busy    = (r_state != c_st_run);
  assign sw_done = r_sw_done;
  assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_dff_clk_switch_n.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dff_clk_switch_n                                           |
// | Brief    : Randomized self-checking bench for dff_clk_switch_n with a    |
// |            schedule-based reference model and pulse-width checkers.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dff_clk_switch_n;

  localparam int c_n_ch  = 4;
  localparam int c_sel_w = 2;
  localparam int c_mod   = 1 << c_n_ch;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [c_sel_w-1:0] select;
  logic               clk_out;
  logic [c_sel_w-1:0] cur_sel;
  logic               busy;
  logic               sw_done;
  logic               sel_err;

  logic               rst_n3;
  logic [1:0]         select3;
  logic               clk_out3;
  logic [1:0]         cur_sel3;
  logic               busy3;
  logic               sw_done3;
  logic               sel_err3;

  dff_clk_switch_n #(.N_CH(c_n_ch), .SEL_W(c_sel_w), .RST_SEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .clk_out(clk_out),
    .cur_sel(cur_sel), .busy(busy), .sw_done(sw_done), .sel_err(sel_err)
  );

  dff_clk_switch_n #(.N_CH(3), .SEL_W(2), .RST_SEL(0)) dut3 (
    .clk(clk), .rst_n(rst_n3), .select(select3), .clk_out(clk_out3),
    .cur_sel(cur_sel3), .busy(busy3), .sw_done(sw_done3), .sel_err(sel_err3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a switch is a schedule of absolute edge indices.
  // Edge k sees counter value k mod 2^N_CH.
  int m_k, m_cur, m_tgt, m_d, m_p;
  bit m_active;
  int e_clk, e_done, e_err;

  function automatic int phase(int ch, int k);
    return ((k % c_mod) >> ch) & 1;
  endfunction

  function automatic int first_zero(int ch, int from);
    for (int k = from; k < from + 2 * c_mod; k++)
      if (phase(ch, k) == 0) return k;
    return from;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_k = 0; m_cur = 0; m_tgt = 0; m_active = 0;
      e_clk = 0; e_done = 0; e_err = 0;
    end else begin
      e_done = 0;
      e_err  = 0;
      if (!m_active) begin
        e_clk = phase(m_cur, m_k);
        if (int'(select) >= c_n_ch) begin
          e_err = 1;
        end else if (int'(select) != m_cur) begin
          m_active = 1;
          m_tgt    = int'(select);
          m_d      = first_zero(m_cur, m_k + 1);   // edge where output parks low
          m_p      = first_zero(m_tgt, m_d + 2);   // edge where target takes over
        end
      end else if (m_k < m_d) begin
        e_clk = phase(m_cur, m_k);
      end else begin
        e_clk = 0;
        if (m_k == m_p) begin
          m_cur    = m_tgt;
          m_active = 0;
          e_done   = 1;
        end
      end
      m_k++;
    end
  endtask

  int hi_run = 0, hi_ch = 0, lo_run = 0, lo_dones = 0, n_done = 0;

  task automatic cycle();
    logic rst_at_edge;
    @(posedge clk);
    rst_at_edge = rst_n;
    model_step();
    #1;
    check("clk_out", clk_out, e_clk);
    check("cur_sel", cur_sel, m_cur);
    check("busy", busy, m_active);
    check("sw_done", sw_done, e_done);
    check("sel_err", sel_err, e_err);
    if (!rst_at_edge) begin
      hi_run = 0; lo_run = 0; lo_dones = 0;
    end else if (clk_out) begin
      if (lo_run > 0 && lo_dones > 0) begin
        check("low_min", lo_run >= 2, 1);
        if (lo_dones == 1) check("low_max", lo_run <= 2 * c_mod + 2, 1);
      end
      lo_run = 0; lo_dones = 0;
      if (hi_run == 0) hi_ch = int'(cur_sel);
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        check("high_len", hi_run, 1 << hi_ch);
        hi_run = 0;
      end
      lo_run++;
      if (sw_done) lo_dones++;
    end
    if (sw_done) n_done++;
  endtask

  initial begin
    bit found;
    int done_before;
    rst_n = 0; select = 0; rst_n3 = 0; select3 = 0;
    repeat (3) cycle();

    // ch0 toggling after release
    rst_n = 1;
    repeat (12) cycle();

    // switch ch0 -> ch3
    select = 3;
    repeat (60) cycle();
    check("cur_ch3", cur_sel, 3);

    // retarget while parking toward ch2
    n_done = 0;
    select = 2;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (m_active && m_k > m_d) found = 1;
    end
    check("wait_park", found, 1);
    select = 1;
    repeat (80) cycle();
    check("two_dones", n_done, 2);
    check("cur_ch1", cur_sel, 1);

    // request while ch3 is three cycles into its high half
    select = 3;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      cycle();
      if (cur_sel == 3 && !busy) found = 1;
    end
    check("wait_ch3", found, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (hi_run == 3) found = 1;
    end
    check("wait_hi3", found, 1);
    select = 0;
    repeat (60) cycle();
    check("cur_ch0", cur_sel, 0);

    // reset during DRAIN aborts the switch
    select = 2;
    cycle();
    check("drain_busy", busy, 1);
    done_before = n_done;
    rst_n = 0;
    cycle();
    rst_n = 1;
    select = 0;
    cycle();
    check("abort_cur", cur_sel, 0);
    check("abort_busy", busy, 0);
    check("abort_nodone", n_done, done_before);

    // randomized select changes and occasional resets
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) select = c_sel_w'($urandom_range(0, c_n_ch - 1));
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end

    // three-channel instance: out-of-range select
    rst_n = 1;
    select = cur_sel;
    cycle();
    rst_n3 = 1; select3 = 0;
    repeat (4) cycle();
    select3 = 3;
    repeat (6) begin
      cycle();
      check("n3_sel_err", sel_err3, 1);
      check("n3_cur", cur_sel3, 0);
      check("n3_busy", busy3, 0);
    end
    select3 = 0;
    cycle();
    check("n3_err_clear", sel_err3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
